// File: rtl/ram_arbiter.sv
// ---------------------------------------------------------------------------
// ram_arbiter
//
// Two-port arbiter and sequencer in front of a single-port on-chip RAM with
// registered read data.
// Port 0 is the CPU memory interface. Port 1 is the loader/debug (UART)
// interface. Requests are served one at a time through a four-state
// sequence: IDLE -> ACCESS -> CAPTURE -> RESP. Each result is returned to the
// winning port with a one-cycle acknowledge pulse. Every output is a
// register.
//
// Optional build macro:
//   RAM_ARB_ROUND_ROBIN_EN  - when defined, simultaneous requests are granted
//                             to the port that was not granted last. When
//                             undefined, port 0 always has fixed priority.
//
// Ports:
//   clk               system clock, rising edge
//   reset_n           asynchronous active-low reset
//   req0/we0/addr0/wdata0 -> ack0/rdata0   port 0 (CPU) request / response
//   req1/we1/addr1/wdata1 -> ack1/rdata1   port 1 (loader) request / response
//   ram_address, ram_data_in, ram_write_enable   drive the RAM
//   ram_data_out      registered RAM read data (1-cycle latency)
// ---------------------------------------------------------------------------
module ram_arbiter #(
    parameter int ADDR_WIDTH = 6,
    parameter int DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  reset_n,

    input  logic                  req0,
    input  logic                  we0,
    input  logic [ADDR_WIDTH-1:0] addr0,
    input  logic [DATA_WIDTH-1:0] wdata0,
    output logic                  ack0,
    output logic [DATA_WIDTH-1:0] rdata0,

    input  logic                  req1,
    input  logic                  we1,
    input  logic [ADDR_WIDTH-1:0] addr1,
    input  logic [DATA_WIDTH-1:0] wdata1,
    output logic                  ack1,
    output logic [DATA_WIDTH-1:0] rdata1,

    output logic [ADDR_WIDTH-1:0] ram_address,
    output logic [DATA_WIDTH-1:0] ram_data_in,
    output logic                  ram_write_enable,
    input  logic [DATA_WIDTH-1:0] ram_data_out
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ACCESS  = 2'd1,
        CAPTURE = 2'd2,
        RESP    = 2'd3
    } state_t;

    state_t state, state_d;

    // grant: port currently being served (0 or 1).
    // op_write: remembers the kind of the current access after
    // ram_write_enable has been cleared.
    logic                  grant, grant_d;
    logic                  op_write, op_write_d;
    logic                  win;

    logic                  ack0_d, ack1_d;
    logic [DATA_WIDTH-1:0] rdata0_d, rdata1_d;
    logic [ADDR_WIDTH-1:0] ram_address_d;
    logic [DATA_WIDTH-1:0] ram_data_in_d;
    logic                  ram_write_enable_d;

`ifdef RAM_ARB_ROUND_ROBIN_EN
    logic                  last_grant, last_grant_d;
`endif

    // Winner selection. This only matters in IDLE when at least one request
    // is high.
    always_comb begin
        // NOTE: every signal written here gets a default first, so no path
        // through the block leaves it unassigned and infers a latch.
        win = 1'b0;
`ifdef RAM_ARB_ROUND_ROBIN_EN
        if (req0 && req1) win = ~last_grant;
        else              win = req1;
`else
        win = ~req0;
`endif
    end

    // Next-state and next-output logic.
    always_comb begin
        state_d            = state;
        grant_d            = grant;
        op_write_d         = op_write;
        ack0_d             = 1'b0;
        ack1_d             = 1'b0;
        rdata0_d           = rdata0;
        rdata1_d           = rdata1;
        ram_address_d      = ram_address;
        ram_data_in_d      = ram_data_in;
        ram_write_enable_d = ram_write_enable;
`ifdef RAM_ARB_ROUND_ROBIN_EN
        last_grant_d       = last_grant;
`endif

        unique case (state)
            IDLE: begin
                if (req0 || req1) begin
                    grant_d            = win;
`ifdef RAM_ARB_ROUND_ROBIN_EN
                    last_grant_d       = win;
`endif
                    ram_address_d      = win ? addr1  : addr0;
                    ram_data_in_d      = win ? wdata1 : wdata0;
                    ram_write_enable_d = win ? we1    : we0;
                    op_write_d         = win ? we1    : we0;
                    state_d            = ACCESS;
                end
            end
            ACCESS: begin
                // The RAM samples the access on the edge that leaves this
                // state, so the write enable is a single-cycle pulse.
                // ram_address keeps its value until the next grant.
                ram_write_enable_d = 1'b0;
                state_d            = CAPTURE;
            end
            CAPTURE: begin
                // Only the granted port is touched. The other port's
                // response registers hold their value.
                if (!op_write) begin
                    if (grant) rdata1_d = ram_data_out;
                    else       rdata0_d = ram_data_out;
                end
                if (grant) ack1_d = 1'b1;
                else       ack0_d = 1'b1;
                state_d = RESP;
            end
            RESP: begin
                // The ack defaults back to 0 on the edge that leaves RESP.
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge reset_n) begin
        // NOTE: sequential state is updated only with non-blocking
        // assignments, so all registers sample their pre-edge inputs.
        if (!reset_n) state <= IDLE;
        else          state <= state_d;
    end

    // Datapath and output registers. Reset takes effect immediately, which
    // aborts any in-flight access and drops the write enable at once.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            grant            <= 1'b0;
            op_write         <= 1'b0;
            ack0             <= 1'b0;
            ack1             <= 1'b0;
            rdata0           <= '0;
            rdata1           <= '0;
            ram_address      <= '0;
            ram_data_in      <= '0;
            ram_write_enable <= 1'b0;
`ifdef RAM_ARB_ROUND_ROBIN_EN
            last_grant       <= 1'b1;
`endif
        end else begin
            grant            <= grant_d;
            op_write         <= op_write_d;
            ack0             <= ack0_d;
            ack1             <= ack1_d;
            rdata0           <= rdata0_d;
            rdata1           <= rdata1_d;
            ram_address      <= ram_address_d;
            ram_data_in      <= ram_data_in_d;
            ram_write_enable <= ram_write_enable_d;
`ifdef RAM_ARB_ROUND_ROBIN_EN
            last_grant       <= last_grant_d;
`endif
        end
    end

endmodule

// File: doc/ram_arbiter.md
Name: ram_arbiter

Overview:
- Two-port arbiter and sequencer in front of the 64 x 8 single-port on-chip RAM.
- Port 0 is the CPU memory interface; port 1 is the loader/debug (UART) interface.
- Serialises requests, drives the RAM address/data/write-enable and captures the registered read data.
- Returns each result to the requester with a one-cycle acknowledge pulse.

Parameters:
- ADDR_WIDTH, 6, RAM address width (64 locations)
- DATA_WIDTH, 8, RAM data width

Ports:
- clk  input  1  system clock, all logic on rising edge
- reset_n  input  1  asynchronous active-low reset
- req0  input  1  port 0 access request, level
- we0  input  1  port 0 write (1) / read (0)
- addr0  input  ADDR_WIDTH  port 0 address
- wdata0  input  DATA_WIDTH  port 0 write data
- ack0  output  1  port 0 completion pulse
- rdata0  output  DATA_WIDTH  port 0 read data, valid when ack0 pulses after a read
- req1, we1, addr1, wdata1, ack1, rdata1: same as port 0, for port 1
- ram_address  output  ADDR_WIDTH  to RAM address
- ram_data_in  output  DATA_WIDTH  to RAM write data
- ram_write_enable  output  1  to RAM write enable
- ram_data_out  input  DATA_WIDTH  from RAM registered read data (1-cycle latency; not updated on a write cycle)

Behaviour:
- Reset (async, reset_n=0):
  - state=IDLE, grant=0, last_grant=1.
  - ack0/ack1=0, rdata0/rdata1=0.
  - ram_address=0, ram_data_in=0, ram_write_enable=0.
  - An in-flight access is aborted with no ack. ram_write_enable drops immediately.
- All outputs are registered.
- FSM states: IDLE -> ACCESS -> CAPTURE -> RESP -> IDLE.
- IDLE:
  - With no req, remain in IDLE and leave all outputs unchanged except ack=0.
  - If req0 or req1 is high, select a winner (arbitration below) and register grant.
  - Register ram_address=addrW, ram_data_in=wdataW, ram_write_enable=weW, then go to ACCESS.
- ACCESS: the RAM performs the operation on this cycle's edge. Clear ram_write_enable (one-cycle write pulse), then go to CAPTURE.
- CAPTURE:
  - ram_data_out is valid.
  - If the access was a read, load rdataW <= ram_data_out. If it was a write, rdataW is unchanged.
  - Assert ackW for the next cycle, then go to RESP.
- RESP: ackW=1 for exactly one cycle, then go to IDLE with ackW=0.
- Latency: request sampled in IDLE at edge N, ack high during cycle N+3. Max one access per 4 cycles.
- ram_address holds its value from ACCESS until the next grant, so there is no spurious address change during a read.
- Requester rules:
  - Hold addr/we/wdata stable from req rise until ack.
  - Drop req in the cycle after ack.
  - A req still high in IDLE after RESP is a new request.
- req dropped mid-transaction: the access still completes and ack is still pulsed. The arbiter never cancels.
- Simultaneous req0 and req1 in IDLE: one winner. The loser stays pending and is served in the next IDLE, so the second ack comes 4 cycles after the first.
- The losing port's ack and rdata are never disturbed.
- Address wrap: none. addr 63 is a normal location and there is no auto-increment.

Optional Feature:
- Macro RAM_ARB_ROUND_ROBIN_EN.
- Defined: round-robin arbitration. On simultaneous requests the port not equal to last_grant wins. last_grant updates on every grant.
- Undefined: fixed priority, port 0 (CPU) always wins. last_grant is unused. Port 1 is served only when req0=0 in IDLE.

Test Plan:
- Reset: hold reset_n=0 mid-write (state ACCESS, we=1) -> ram_write_enable=0 immediately, all outputs 0, state IDLE, no ack after release.
- Port 0 writes 0xA5 to addr 5, then reads addr 5 -> write ack at N+3 with rdata0 unchanged (0x00); read ack at M+3 with rdata0=0xA5.
- Port 1 writes 0x3C to addr 63, then reads addr 63 -> rdata1=0x3C on ack1; ack0 stays 0 throughout.
- req0 and req1 rise together (reads of addr 1=0x11 and addr 2=0x22):
  - Without the macro: ack0 with 0x11 at N+3, then ack1 with 0x22 at N+7.
  - With the macro, after a previous port-0 grant: port 1 is served first.
- Both ports request continuously for 16 accesses:
  - With RAM_ARB_ROUND_ROBIN_EN: grants alternate 0,1,0,1.
  - Without: port 1 gets no ack while req0 is held.
- Port 0 drops req one cycle after issuing a read of addr 10 -> ack0 still pulses at N+3 with rdata0=memory[10].
